// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT stage widths, butterfly state type and helpers
package fft_pkg;

    localparam int FFT_DATA_WIDTH = 9;
    localparam int FFT_SIZE       = 16;
    localparam int FFT_IN_SIZE    = 16;

    typedef enum logic {
        FILL = 1'b0,
        BFLY = 1'b1
    } bfly_state_t;

    typedef struct packed {
        logic signed [FFT_DATA_WIDTH:0] i;
        logic signed [FFT_DATA_WIDTH:0] q;
    } cplx_t;

    function automatic logic signed [FFT_DATA_WIDTH:0] sext1(input logic signed [FFT_DATA_WIDTH-1:0] x);
        return {x[FFT_DATA_WIDTH-1], x};
    endfunction

endpackage

// File: rtl/bfly2_lane.sv
// rtl/bfly2_lane.sv - single-lane complex add/sub, one bit of growth so results never wrap
module bfly2_lane
    import fft_pkg::*;
#(
    parameter int DW = FFT_DATA_WIDTH
) (
    input  logic signed [DW-1:0] i_a_i,
    input  logic signed [DW-1:0] i_a_q,
    input  logic signed [DW-1:0] i_b_i,
    input  logic signed [DW-1:0] i_b_q,
    output logic signed [DW:0]   o_sum_i,
    output logic signed [DW:0]   o_sum_q,
    output logic signed [DW:0]   o_diff_i,
    output logic signed [DW:0]   o_diff_q
);

    logic signed [DW:0] w_a_i;
    logic signed [DW:0] w_a_q;
    logic signed [DW:0] w_b_i;
    logic signed [DW:0] w_b_q;

    assign w_a_i = {i_a_i[DW-1], i_a_i};
    assign w_a_q = {i_a_q[DW-1], i_a_q};
    assign w_b_i = {i_b_i[DW-1], i_b_i};
    assign w_b_q = {i_b_q[DW-1], i_b_q};

    assign o_sum_i  = w_a_i + w_b_i;
    assign o_sum_q  = w_a_q + w_b_q;
    assign o_diff_i = w_a_i - w_b_i;
    assign o_diff_q = w_a_q - w_b_q;

endmodule

// File: rtl/bfly_r2_stage.sv
// rtl/bfly_r2_stage.sv - radix-2 DIF butterfly stage: sums streamed live, differences buffered and drained after the frame
module bfly_r2_stage
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = FFT_DATA_WIDTH,
    parameter int SIZE       = FFT_SIZE,
    parameter int IN_SIZE    = FFT_IN_SIZE
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              din_valid,
    input  logic [IN_SIZE-1:0][DATA_WIDTH-1:0] din_i,
    input  logic [IN_SIZE-1:0][DATA_WIDTH-1:0] din_q,
    input  logic [IN_SIZE-1:0][DATA_WIDTH-1:0] dly_i,
    input  logic [IN_SIZE-1:0][DATA_WIDTH-1:0] dly_q,
    output logic [IN_SIZE-1:0][DATA_WIDTH:0]   dout_i,
    output logic [IN_SIZE-1:0][DATA_WIDTH:0]   dout_q,
    output logic                              dout_valid,
    output logic                              dout_diff,
    output logic                              dout_last,
    output logic                              busy
);

    localparam int CW = $clog2(2 * SIZE);
    localparam int KW = $clog2(SIZE);
    localparam logic [CW-1:0] LAST_FILL  = CW'(SIZE - 1);
    localparam logic [CW-1:0] FIRST_BFLY = CW'(SIZE);
    localparam logic [CW-1:0] LAST_BFLY  = CW'(2 * SIZE - 1);
    localparam logic [KW-1:0] LAST_DRAIN = KW'(SIZE - 1);

    logic [IN_SIZE-1:0][DATA_WIDTH:0] w_sum_i;
    logic [IN_SIZE-1:0][DATA_WIDTH:0] w_sum_q;
    logic [IN_SIZE-1:0][DATA_WIDTH:0] w_diff_i;
    logic [IN_SIZE-1:0][DATA_WIDTH:0] w_diff_q;
    logic [IN_SIZE-1:0][DATA_WIDTH:0] r_buf_i [SIZE];
    logic [IN_SIZE-1:0][DATA_WIDTH:0] r_buf_q [SIZE];

    bfly_state_t     r_state;
    logic [CW-1:0]   r_blk_cnt;
    logic            r_drain_act;
    logic [KW-1:0]   r_drain_cnt;
    logic [KW-1:0]   w_k;
    logic            w_bfly_wr;

    for (genvar n = 0; n < IN_SIZE; n++) begin : g_lane
        bfly2_lane #(.DW(DATA_WIDTH)) u_lane (
            .i_a_i    (dly_i[n]),
            .i_a_q    (dly_q[n]),
            .i_b_i    (din_i[n]),
            .i_b_q    (din_q[n]),
            .o_sum_i  (w_sum_i[n]),
            .o_sum_q  (w_sum_q[n]),
            .o_diff_i (w_diff_i[n]),
            .o_diff_q (w_diff_q[n])
        );
    end

    assign w_k       = KW'(r_blk_cnt - FIRST_BFLY);
    assign w_bfly_wr = (r_state == BFLY) && din_valid;
    assign busy      = (r_state == BFLY) | r_drain_act;

    // Buffer has no reset: entries are always written before the drain reads them.
    always_ff @(posedge clk) begin
        if (w_bfly_wr) begin
            r_buf_i[w_k] <= w_diff_i;
            r_buf_q[w_k] <= w_diff_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= FILL;
            r_blk_cnt   <= '0;
            r_drain_act <= 1'b0;
            r_drain_cnt <= '0;
            dout_i      <= '0;
            dout_q      <= '0;
            dout_valid  <= 1'b0;
            dout_diff   <= 1'b0;
            dout_last   <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            dout_diff  <= 1'b0;
            dout_last  <= 1'b0;

            if (r_drain_act) begin
                dout_i     <= r_buf_i[r_drain_cnt];
                dout_q     <= r_buf_q[r_drain_cnt];
                dout_valid <= 1'b1;
                dout_diff  <= 1'b1;
                dout_last  <= (r_drain_cnt == LAST_DRAIN);
                if (r_drain_cnt == LAST_DRAIN) begin
                    r_drain_act <= 1'b0;
                    r_drain_cnt <= '0;
                end else begin
                    r_drain_cnt <= r_drain_cnt + 1'b1;
                end
            end

            // The next frame cannot reach BFLY until the drain has finished, so these never overlap.
            if (din_valid) begin
                case (r_state)
                    FILL: begin
                        if (r_blk_cnt == LAST_FILL) begin
                            r_state   <= BFLY;
                            r_blk_cnt <= FIRST_BFLY;
                        end else if (r_blk_cnt < LAST_FILL) begin
                            r_blk_cnt <= r_blk_cnt + 1'b1;
                        end else begin
                            r_blk_cnt <= '0;
                        end
                    end
                    BFLY: begin
                        dout_i     <= w_sum_i;
                        dout_q     <= w_sum_q;
                        dout_valid <= 1'b1;
                        if (r_blk_cnt == LAST_BFLY) begin
                            r_state     <= FILL;
                            r_blk_cnt   <= '0;
                            r_drain_act <= 1'b1;
                            r_drain_cnt <= '0;
                        end else if (r_blk_cnt >= FIRST_BFLY) begin
                            r_blk_cnt <= r_blk_cnt + 1'b1;
                        end else begin
                            r_state   <= FILL;
                            r_blk_cnt <= '0;
                        end
                    end
                    default: begin
                        r_state   <= FILL;
                        r_blk_cnt <= '0;
                    end
                endcase
            end
        end
    end

    a_no_buf_collision: assert property (@(posedge clk) disable iff (!rstn)
        !(r_drain_act && w_bfly_wr));

endmodule

// File: tb/tb_bfly_r2_stage.sv
// tb/tb_bfly_r2_stage.sv - scoreboard bench for bfly_r2_stage with directed and random frames
module tb_bfly_r2_stage;
    import fft_pkg::*;

    localparam int DW = FFT_DATA_WIDTH;
    localparam int OW = FFT_DATA_WIDTH + 1;
    localparam int SZ = FFT_SIZE;
    localparam int NL = FFT_IN_SIZE;

    typedef logic [NL-1:0][DW-1:0] blk_t;
    typedef logic [NL-1:0][OW-1:0] oblk_t;
    typedef struct {
        oblk_t i;
        oblk_t q;
        logic  diff;
        logic  last;
        int    cyc;
    } exp_t;

    logic  clk = 1'b0;
    logic  rstn = 1'b0;
    logic  din_valid = 1'b0;
    blk_t  din_i = '0;
    blk_t  din_q = '0;
    blk_t  dly_i = '0;
    blk_t  dly_q = '0;
    oblk_t dout_i;
    oblk_t dout_q;
    logic  dout_valid;
    logic  dout_diff;
    logic  dout_last;
    logic  busy;

    int    cyc = 0;
    int    n_checks = 0;
    int    n_fail = 0;
    exp_t  sb[$];

    blk_t  fill_i[SZ], fill_q[SZ], bfly_i[SZ], bfly_q[SZ];
    blk_t  prev_i[SZ], prev_q[SZ];
    oblk_t es_i[SZ], es_q[SZ], ed_i[SZ], ed_q[SZ];

    bfly_r2_stage dut (
        .clk        (clk),
        .rstn       (rstn),
        .din_valid  (din_valid),
        .din_i      (din_i),
        .din_q      (din_q),
        .dly_i      (dly_i),
        .dly_q      (dly_q),
        .dout_i     (dout_i),
        .dout_q     (dout_q),
        .dout_valid (dout_valid),
        .dout_diff  (dout_diff),
        .dout_last  (dout_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (dout_valid) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got block diff=%0b at cycle %0d, expected none", dout_diff, cyc);
                end else begin
                    e = sb.pop_front();
                    check("dout_i", 256'(dout_i), 256'(e.i));
                    check("dout_q", 256'(dout_q), 256'(e.q));
                    check("dout_diff", 256'(dout_diff), 256'(e.diff));
                    check("dout_last", 256'(dout_last), 256'(e.last));
                    check("out_cycle", 256'(cyc), 256'(e.cyc));
                end
            end else begin
                check("idle_flags", 256'({dout_diff, dout_last}), 256'(0));
            end
        end
    end

    task automatic set_basic();
        for (int k = 0; k < SZ; k++) begin
            for (int n = 0; n < NL; n++) begin
                fill_i[k][n] = DW'(k);
                fill_q[k][n] = DW'(-k);
                bfly_i[k][n] = DW'(1);
                bfly_q[k][n] = DW'(2);
                es_i[k][n]   = OW'(k + 1);
                es_q[k][n]   = OW'(2 - k);
                ed_i[k][n]   = OW'(k - 1);
                ed_q[k][n]   = OW'(-k - 2);
            end
        end
    endtask

    task automatic set_extreme();
        for (int k = 0; k < SZ; k++) begin
            for (int n = 0; n < NL; n++) begin
                if (n % 2 == 0) begin
                    fill_i[k][n] = DW'(255);  bfly_i[k][n] = DW'(255);
                    es_i[k][n]   = OW'(510);  ed_i[k][n]   = OW'(0);
                    fill_q[k][n] = DW'(-256); bfly_q[k][n] = DW'(-256);
                    es_q[k][n]   = OW'(-512); ed_q[k][n]   = OW'(0);
                end else begin
                    fill_i[k][n] = DW'(-256); bfly_i[k][n] = DW'(255);
                    es_i[k][n]   = OW'(-1);   ed_i[k][n]   = OW'(-511);
                    fill_q[k][n] = DW'(255);  bfly_q[k][n] = DW'(-256);
                    es_q[k][n]   = OW'(-1);   ed_q[k][n]   = OW'(511);
                end
            end
        end
    endtask

    task automatic set_random();
        int a, b;
        for (int k = 0; k < SZ; k++) begin
            for (int n = 0; n < NL; n++) begin
                fill_i[k][n] = DW'($urandom);
                fill_q[k][n] = DW'($urandom);
                bfly_i[k][n] = DW'($urandom);
                bfly_q[k][n] = DW'($urandom);
                a = int'($signed(fill_i[k][n]));
                b = int'($signed(bfly_i[k][n]));
                es_i[k][n] = OW'(a + b);
                ed_i[k][n] = OW'(a - b);
                a = int'($signed(fill_q[k][n]));
                b = int'($signed(bfly_q[k][n]));
                es_q[k][n] = OW'(a + b);
                ed_q[k][n] = OW'(a - b);
            end
        end
    endtask

    task automatic clear_delay_line();
        for (int k = 0; k < SZ; k++) begin
            prev_i[k] = '0;
            prev_q[k] = '0;
        end
    endtask

    task automatic do_abort();
        @(negedge clk);
        rstn = 1'b0;
        din_valid = 1'b0;
        #1;
        check("rst_valid", 256'(dout_valid), 256'(0));
        check("rst_dout_i", 256'(dout_i), 256'(0));
        check("rst_dout_q", 256'(dout_q), 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_pending", 256'(sb.size()), 256'(0));
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        clear_delay_line();
    endtask

    task automatic send_frame(input int gap, input int abort_k);
        int pb = -1;
        int k;
        for (int b = 0; b < 2 * SZ; b++) begin
            if (abort_k >= 0 && b == SZ + abort_k) begin
                do_abort();
                return;
            end
            @(negedge clk);
            if (pb >= SZ - 1) check("busy_bfly", 256'(busy), 256'(1));
            din_valid = 1'b1;
            if (b < SZ) begin
                din_i = fill_i[b];
                din_q = fill_q[b];
                dly_i = prev_i[b];
                dly_q = prev_q[b];
            end else begin
                k = b - SZ;
                din_i = bfly_i[k];
                din_q = bfly_q[k];
                dly_i = fill_i[k];
                dly_q = fill_q[k];
                sb.push_back('{es_i[k], es_q[k], 1'b0, 1'b0, cyc + 1});
                if (k == SZ - 1) begin
                    for (int j = 0; j < SZ; j++)
                        sb.push_back('{ed_i[j], ed_q[j], 1'b1, (j == SZ - 1), cyc + 2 + j});
                end
            end
            pb = b;
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                if (pb >= SZ - 1) check("busy_gap", 256'(busy), 256'(1));
                din_valid = 1'b0;
            end
        end
        prev_i = bfly_i;
        prev_q = bfly_q;
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        din_valid = 1'b0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 256'(sb.size()), 256'(0));
            sb.delete();
        end
        check("busy_idle", 256'(busy), 256'(0));
    endtask

    initial begin
        clear_delay_line();
        repeat (3) @(negedge clk);
        check("reset_valid", 256'(dout_valid), 256'(0));
        check("reset_dout_i", 256'(dout_i), 256'(0));
        check("reset_dout_q", 256'(dout_q), 256'(0));
        check("reset_flags", 256'({dout_diff, dout_last}), 256'(0));
        check("reset_busy", 256'(busy), 256'(0));
        rstn = 1'b1;

        set_basic();
        send_frame(0, -1);
        wait_idle();

        set_extreme();
        send_frame(0, -1);
        wait_idle();

        set_basic();
        send_frame(2, -1);
        wait_idle();

        set_basic();
        send_frame(0, -1);
        send_frame(0, -1);
        wait_idle();

        set_basic();
        send_frame(0, 7);
        repeat (3 * SZ) @(negedge clk);
        check("post_abort_busy", 256'(busy), 256'(0));
        check("post_abort_pending", 256'(sb.size()), 256'(0));
        send_frame(0, -1);
        wait_idle();

        repeat (4) begin
            set_random();
            send_frame(0, -1);
        end
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
